// File: rtl/mux2_arbiter.sv
// -----------------------------------------------------------------------------
// mux2_arbiter
//
// Purpose:
//   This block lets two requesters share one 2:1 data mux.
//   - It grants the mux to one requester at a time and drives the select.
//   - The selected beat goes into a single-entry output slot.
//   - The slot uses a valid/ready handshake toward the downstream consumer.
//   - A grant is limited to MAX_BURST accepted beats, so neither requester
//     can hold the mux for ever.
//
// Arbitration:
//   - Default build: round-robin.
//   - With MUX2_ARB_FIXED_PRIORITY_EN defined, req0 always wins an
//     arbitration point, and requester 1 may starve.
//
// Parameters:
//   WIDTH      data width of each requester and of the output slot
//   MAX_BURST  maximum accepted beats per grant (1..15)
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   req0/req1  requester has a beat available
//   data0/1    requester data
//   ack0/ack1  requester beat accepted this cycle (combinational)
//   sel        mux select: 0 = data0, 1 = data1 (registered)
//   out_valid  output slot holds a beat
//   out_data   output slot data
//   out_ready  downstream accepts the beat
//   busy       arbiter currently has an owner
// -----------------------------------------------------------------------------
module mux2_arbiter #(
  parameter int WIDTH     = 2,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t     state;
  logic       last;
  logic [3:0] burst_cnt;

  logic slot_free;
  logic accept;
  logic owner_req;
  logic release_now;
  logic grant_valid;
  logic grant_id;

  // sel is 0 in OWN0 and 1 in OWN1, and it holds the most recent owner
  // in IDLE. That is exactly the value of `last`, so sel is simply that
  // register.
  assign sel  = last;
  assign busy = (state != IDLE);

  assign slot_free = !out_valid || out_ready;
  assign ack0      = (state == OWN0) && req0 && slot_free;
  assign ack1      = (state == OWN1) && req1 && slot_free;
  assign accept    = ack0 || ack1;

  // While an owner exists, `last` names it, so sel also picks the
  // owner's request.
  assign owner_req   = sel ? req1 : req0;
  assign release_now = !owner_req || (accept && (burst_cnt == BURST_LAST));

`ifdef MUX2_ARB_FIXED_PRIORITY_EN
  // req0 wins every arbitration point.
  assign grant_valid = req0 || req1;
  assign grant_id    = !req0;
`else
  // Round-robin.
  // - If both requesters are asking, the one that did not own last wins.
  // - If only one is asking, it wins.
  // - At a release, `last` is the current owner. So the rule prefers the
  //   other requester and re-grants the owner only when nobody else asks.
  assign grant_valid = req0 || req1;
  assign grant_id    = (req0 && req1) ? !last : req1;
`endif

  // Ownership state machine.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      burst_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state     <= grant_id ? OWN1 : OWN0;
            last      <= grant_id;
            burst_cnt <= 4'd0;
          end
        end
        default: begin
          if (release_now) begin
            // Hand over directly, with no IDLE bubble, when someone is asking.
            if (grant_valid) begin
              state     <= grant_id ? OWN1 : OWN0;
              last      <= grant_id;
              burst_cnt <= 4'd0;
            end else begin
              state <= IDLE;
            end
          end else if (accept) begin
            burst_cnt <= burst_cnt + 4'd1;
          end
        end
      endcase
    end
  end

  // Single-entry output slot.
  // - An accepted beat always overwrites the slot.
  // - The slot empties only when it drains with no new beat arriving.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel ? data1 : data0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux2_arbiter
//
// Randomized bench for mux2_arbiter with a behavioural reference model.
// - Each requester holds a pending beat until its ack.
// - The model tracks the owner, the last owner, the beat count and the
//   slot occupancy as plain integers.
// - Each beat the model expects to be accepted is queued.
// - A monitor pops the queue on every output handshake.
// -----------------------------------------------------------------------------
module tb_mux2_arbiter;
  localparam int WIDTH     = 2;
  localparam int MAX_BURST = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, req1, out_ready;
  logic [WIDTH-1:0] data0, data1;
  logic             ack0, ack1, sel, out_valid, busy;
  logic [WIDTH-1:0] out_data;

  always #5 clk = ~clk;

  mux2_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .sel(sel), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  // Reference model: owner -1 means nobody owns the mux.
  int m_owner, m_last, m_cnt;
  bit m_valid;
  // Requester-side state.
  bit               has[2];
  bit               acked[2];
  logic [WIDTH-1:0] dat[2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_last  = 1;
    m_cnt   = 0;
    m_valid = 1'b0;
  endfunction

  // Choose who owns the mux after an arbitration point.
  // cur is the current owner, or -1 in IDLE.
  function automatic int choose(input bit r0, input bit r1, input int cur, input int last);
    bit r[2];
    r[0] = r0;
    r[1] = r1;
`ifdef MUX2_ARB_FIXED_PRIORITY_EN
    if (r[0]) return 0;
    if (r[1]) return 1;
    return -1;
`else
    if (cur < 0) begin
      if (r[0] && r[1]) return 1 - last;
      if (r[0]) return 0;
      if (r[1]) return 1;
      return -1;
    end
    if (r[1 - cur]) return 1 - cur;   // the other requester goes first
    if (r[cur]) return cur;           // burst expiry with nobody else asking
    return -1;
`endif
  endfunction

  // One clock cycle: drive inputs, check outputs, advance the model.
  // p0, p1 and pr are percentages.
  task automatic cycle(input int p0, input int p1, input int pr);
    bit e[2];
    bit r[2];
    bit free;
    bit acc;
    bit rel;
    int nxt;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (acked[i]) has[i] = 1'b0;
      if (!has[i] && ($urandom_range(99) < ((i == 0) ? p0 : p1))) begin
        has[i] = 1'b1;
        dat[i] = WIDTH'($urandom);
      end
      r[i] = has[i];
    end
    req0      = has[0];
    req1      = has[1];
    data0     = has[0] ? dat[0] : WIDTH'($urandom);
    data1     = has[1] ? dat[1] : WIDTH'($urandom);
    out_ready = ($urandom_range(99) < pr);
    #1;
    free = !m_valid || out_ready;
    for (int i = 0; i < 2; i++) e[i] = (m_owner == i) && r[i] && free;
    check("ack0", int'(ack0), int'(e[0]));
    check("ack1", int'(ack1), int'(e[1]));
    check("sel", int'(sel), m_last);
    check("busy", int'(busy), int'(m_owner >= 0));
    check("out_valid", int'(out_valid), int'(m_valid));
    acc = e[0] || e[1];
    acked[0] = e[0];
    acked[1] = e[1];
    if (acc) exp_q.push_back(dat[m_owner]);
    // Slot occupancy for the coming edge.
    if (acc) m_valid = 1'b1;
    else if (m_valid && out_ready) m_valid = 1'b0;
    // Ownership for the coming edge.
    if (m_owner < 0) begin
      nxt = choose(r[0], r[1], -1, m_last);
      if (nxt >= 0) begin
        m_owner = nxt;
        m_last  = nxt;
        m_cnt   = 0;
      end
    end else begin
      rel = !r[m_owner] || (acc && (m_cnt == MAX_BURST - 1));
      if (rel) begin
        nxt = choose(r[0], r[1], m_owner, m_last);
        m_owner = nxt;
        if (nxt >= 0) m_last = nxt;
        m_cnt = 0;
      end else if (acc) begin
        m_cnt++;
      end
    end
  endtask

  // Monitor: pop and compare on every output handshake.
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_beat actual=%0d required=none (no beat expected) at %0t", out_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_data", int'(out_data), int'(e));
          $display("beat out_data=%0d expected=%0d at %0t", out_data, e, $time);
        end
      end
    end
  end

  task automatic check_reset_values();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_sel", int'(sel), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_ack0", int'(ack0), 0);
    check("rst_ack1", int'(ack1), 0);
  endtask

  initial begin
    reset     = 1'b1;
    req0      = 1'b0;
    req1      = 1'b0;
    data0     = '0;
    data1     = '0;
    out_ready = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      has[i]   = 1'b0;
      acked[i] = 1'b0;
      dat[i]   = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    #1 reset = 1'b0;

    // Single requester, always ready.
    repeat (30) cycle(100, 0, 100);
    // Both requesters always asking.
    repeat (40) cycle(100, 100, 100);
    // Random traffic with heavy backpressure.
    repeat (200) cycle(70, 70, 50);

    // Reset mid-burst, ideally during OWN1 with a full slot.
    for (int k = 0; k < 200 && !(m_owner == 1 && m_valid); k++) cycle(80, 80, 30);
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check_reset_values();
    model_reset();
    exp_q.delete();
    acked[0] = 1'b0;
    acked[1] = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;

    // Random traffic after reset.
    repeat (200) cycle(50, 80, 70);
    // Drain the pending beats.
    repeat (12) cycle(0, 0, 100);
    @(negedge clk);
    #3;
    check("drained_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux2_arbiter.md
Name: mux2_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 2:1 data mux between two requesters.
- Each requester presents a request and WIDTH-bit data. The block grants one owner at a time and drives the mux select.
- The selected data is registered into a single-entry output slot with a valid/ready handshake toward the downstream consumer.
- Bursts are limited to MAX_BURST beats so that neither requester can starve the other.

Parameters:
- WIDTH, 2, data width of each requester and of the output.
- MAX_BURST, 4, maximum accepted beats per grant. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 has a beat available.
- data0  input  WIDTH  requester 0 data.
- ack0  output  1  requester 0 beat accepted this cycle.
- req1  input  1  requester 1 has a beat available.
- data1  input  WIDTH  requester 1 data.
- ack1  output  1  requester 1 beat accepted this cycle.
- sel  output  1  mux select: 0 selects data0, 1 selects data1.
- out_valid  output  1  output slot holds a beat.
- out_data  output  WIDTH  output slot data.
- out_ready  input  1  downstream accepts the beat.
- busy  output  1  state is not IDLE.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (reset).
- Reset values:
  - state=IDLE, last=1, burst_cnt=0.
  - out_valid=0, out_data=0, sel=1 (sel tracks last in IDLE).
  - ack0=ack1=0, busy=0.
- States:
  - IDLE: no owner.
  - OWN0: requester 0 owns the mux.
  - OWN1: requester 1 owns the mux.
- sel: equals 0 in OWN0 and 1 in OWN1. In IDLE it holds `last`, the most recent owner. sel is registered with the state.
- slot_free = !out_valid | out_ready.
- ackN (combinational) = (state==OWNN) & reqN & slot_free. No ack is ever issued in IDLE.
- Accepted beat: on the clock edge where ackN=1, out_data <= dataN (through the mux at sel) and out_valid <= 1.
- Draining: if out_valid & out_ready and no beat is accepted, out_valid <= 0. Accept and drain in the same cycle leaves out_valid=1 holding the new data.
- Latency: a beat accepted at edge k appears on out_data/out_valid after edge k.
- IDLE transitions:
  - req0 & req1: grant the requester != last.
  - Exactly one request: grant that requester.
  - Grant takes one cycle, so the first ack comes the cycle after the grant edge.
  - On grant: last <= new owner, burst_cnt <= 0.
- OWNn release conditions:
  - Owner req low. Ownership is released at the next edge with no ack that cycle.
  - An accepted beat with burst_cnt == MAX_BURST-1.
- Otherwise, an accepted beat increments burst_cnt. A stall (!slot_free) holds all state.
- On release:
  - Other requester's req high: go directly to OWN(other), burst_cnt <= 0, last <= other. There is no IDLE bubble.
  - Else, owner's req still high (burst expiry only): re-grant the same owner with burst_cnt <= 0.
  - Else: go to IDLE.
- Requester contract: a requester must hold reqN and dataN stable until ackN. The arbiter does not check this.
- Mid-operation reset: reset asserted at any point forces the reset values immediately. Any beat held in the output slot is discarded.
- WIDTH applies uniformly. No arithmetic is performed on the data. burst_cnt is 4 bits.

Optional Feature:
- MUX2_ARB_FIXED_PRIORITY_EN
- Defined:
  - At every arbitration point (IDLE grant and release), req0 wins over req1 regardless of last.
  - On burst expiry of OWN0 with req0 still high, OWN0 is re-granted even if req1 is high. Requester 1 may starve.
  - `last` is still updated so that sel in IDLE is unchanged.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Single requester:
  - Stimulus: reset; req0=1 with data0 = 2'b01, 2'b10, 2'b11 on successive acks; out_ready=1; req1=0.
  - Response: grant at edge 1; ack0 high for 3 cycles; out_data sequence 01, 10, 11; sel=0; burst limit re-grant after the 4th beat if req0 is still high.
- Simultaneous first request:
  - Stimulus: after reset, req0=req1=1.
  - Response: OWN0 first (last=1); after 4 beats, direct switch to OWN1 with no bubble; ack1 on the next cycle; sel=1.
- Backpressure:
  - Stimulus: OWN1 with req1 held; out_ready=0 after the first beat.
  - Response: out_valid=1 with data held; ack1=0; burst_cnt frozen. out_ready=1 resumes with one beat per cycle.
- Early release:
  - Stimulus: OWN0; req0 drops after 2 beats while req1=1.
  - Response: switch to OWN1; burst_cnt=0; ack0 never asserted when req0=0.
- Reset mid-burst:
  - Stimulus: reset asserted asynchronously between edges during OWN1 with out_valid=1.
  - Response: out_valid=0, busy=0, sel=1, ack0=ack1=0 immediately, before the next clock edge.
- Fixed priority:
  - Stimulus: macro defined; req0=req1=1 continuously for 12 cycles.
  - Response: only ack0 pulses; sel stays 0; ack1 never asserts.
